// File: rtl/md_hazard_ctrl_if.sv
// Request/response bundle between the HI/LO issue controller and the multiply/divide unit.
interface md_hazard_ctrl_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_d1;
  logic [31:0] md_d2;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  modport master (
    output md_start, md_op, md_d1, md_d2,
    input  md_busy, md_hi, md_lo
  );

  modport slave (
    input  md_start, md_op, md_d1, md_d2,
    output md_busy, md_hi, md_lo
  );
endinterface

// File: rtl/md_hazard_ctrl.sv
// EX-stage issue/hazard controller for the multiply/divide unit: decode, latency shadow, D-stall, mfhi/mflo select.
// Optional MD_HAZ_PERF_EN adds a saturating stall_cycles counter output.
//
// state | meaning
// IDLE  | unit free, cnt == 0, a start may be issued
// BUSY  | mult/div in flight, cnt counts remaining busy cycles down to 1
module md_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        id_cls,
  input  logic [3:0]        ex_cls,
  input  logic              ex_valid,
  input  logic [31:0]       ex_rs,
  input  logic [31:0]       ex_rt,
  md_hazard_ctrl_if.master  md,
  output logic              stall_d,
  output logic [31:0]       ex_mf_data,
  output logic              proto_err
`ifdef MD_HAZ_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             proto_err_nxt;
  logic             occupied;
  logic             ex_md;
  logic             ex_muldiv;
  logic             ex_is_mul;
  logic             ex_is_div;
  logic             id_hilo;

  always_comb begin
    ex_is_mul = (ex_cls == 4'd1) || (ex_cls == 4'd2);
    ex_is_div = (ex_cls == 4'd3) || (ex_cls == 4'd4);
    ex_muldiv = ex_is_mul || ex_is_div;
    ex_md     = ex_valid && (ex_cls >= 4'd1) && (ex_cls <= 4'd6);
    id_hilo   = (id_cls >= 4'd1) && (id_cls <= 4'd8);
    occupied  = (cnt != '0);
  end

  always_comb begin
    md.md_start = ex_md && !occupied;
    md.md_op    = 3'd0;
    if ((ex_cls >= 4'd1) && (ex_cls <= 4'd6))
      md.md_op = 3'(ex_cls - 4'd1);
    md.md_d1    = ex_rs;
    md.md_d2    = ex_rt;
    // The unit only raises Busy after the start edge, so the start cycle stalls on its own term.
    stall_d     = id_hilo && (occupied || (md.md_start && ex_muldiv));
    ex_mf_data  = 32'd0;
    if (ex_cls == 4'd7)
      ex_mf_data = md.md_hi;
    else if (ex_cls == 4'd8)
      ex_mf_data = md.md_lo;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (md.md_start && ex_is_mul) begin
          cnt_nxt   = CNT_W'(MULT_LAT);
          state_nxt = BUSY;
        end else if (md.md_start && ex_is_div) begin
          cnt_nxt   = CNT_W'(DIV_LAT);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Shadow counter must track the unit's Busy exactly; any issue while occupied means upstream ignored stall_d.
  always_comb begin
    proto_err_nxt = proto_err || (occupied != md.md_busy) || (ex_md && occupied);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      proto_err <= proto_err_nxt;
    end
  end

`ifdef MD_HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= 32'd0;
    else if (stall_d && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Directed bench for md_hazard_ctrl with a behavioural multiply/divide unit and an mfhi/mflo result scoreboard.
module tb_md_hazard_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  localparam logic [3:0] C_NONE = 4'd0, C_MULT = 4'd1, C_DIV = 4'd3, C_DIVU = 4'd4,
                         C_MTHI = 4'd5, C_MFHI = 4'd7, C_MFLO = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  id_cls, ex_cls;
  logic        ex_valid;
  logic [31:0] ex_rs, ex_rt;
  logic        stall_d;
  logic [31:0] ex_mf_data;
  logic        proto_err;
`ifdef MD_HAZ_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  md_hazard_ctrl_if mdi ();

  md_hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_cls     (id_cls),
    .ex_cls     (ex_cls),
    .ex_valid   (ex_valid),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .md         (mdi),
    .stall_d    (stall_d),
    .ex_mf_data (ex_mf_data),
    .proto_err  (proto_err)
`ifdef MD_HAZ_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural unit: Busy rises on the start edge, HI/LO land on the LAT-th edge after it.
  logic               u_busy;
  logic               busy_kill;
  int                 u_cnt;
  logic [31:0]        u_hi, u_lo, p_hi, p_lo;
  logic signed [63:0] s_prod;
  logic [63:0]        u_prod;
  logic [31:0]        s_q, s_r, u_q, u_r;

  assign s_prod = $signed({{32{mdi.md_d1[31]}}, mdi.md_d1}) * $signed({{32{mdi.md_d2[31]}}, mdi.md_d2});
  assign u_prod = {32'd0, mdi.md_d1} * {32'd0, mdi.md_d2};
  assign s_q = (mdi.md_d2 == 0) ? 32'hFFFF_FFFF : 32'($signed(mdi.md_d1) / $signed(mdi.md_d2));
  assign s_r = (mdi.md_d2 == 0) ? mdi.md_d1     : 32'($signed(mdi.md_d1) % $signed(mdi.md_d2));
  assign u_q = (mdi.md_d2 == 0) ? 32'hFFFF_FFFF : mdi.md_d1 / mdi.md_d2;
  assign u_r = (mdi.md_d2 == 0) ? mdi.md_d1     : mdi.md_d1 % mdi.md_d2;

  assign mdi.md_busy = u_busy & ~busy_kill;
  assign mdi.md_hi   = u_hi;
  assign mdi.md_lo   = u_lo;

  always @(posedge clk) begin
    if (reset) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
      u_hi   <= 32'd0;
      u_lo   <= 32'd0;
    end else if (mdi.md_start) begin
      case (mdi.md_op)
        3'd0: begin p_hi <= s_prod[63:32]; p_lo <= s_prod[31:0]; u_cnt <= MULT_LAT; u_busy <= 1'b1; end
        3'd1: begin p_hi <= u_prod[63:32]; p_lo <= u_prod[31:0]; u_cnt <= MULT_LAT; u_busy <= 1'b1; end
        3'd2: begin p_hi <= s_r; p_lo <= s_q; u_cnt <= DIV_LAT; u_busy <= 1'b1; end
        3'd3: begin p_hi <= u_r; p_lo <= u_q; u_cnt <= DIV_LAT; u_busy <= 1'b1; end
        3'd4: u_hi <= mdi.md_d1;
        3'd5: u_lo <= mdi.md_d1;
        default: ;
      endcase
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        u_busy <= 1'b0;
        u_hi   <= p_hi;
        u_lo   <= p_lo;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, ex_mf_data);
    end else begin
      check(tag, ex_mf_data, exp_q.pop_front());
    end
  endtask

  task automatic set_ex(input logic [3:0] cls, input logic v, input logic [31:0] rs, input logic [31:0] rt);
    ex_cls   = cls;
    ex_valid = v;
    ex_rs    = rs;
    ex_rt    = rt;
  endtask

  // Counts consecutive stalled cycles from the current one; bounded so a stuck stall still ends.
  task automatic wait_stall(output int n);
    n = 0;
    while (stall_d === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    busy_kill = 1'b0;
    id_cls = C_NONE;
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_start", mdi.md_start, 1'b0);
    check("rst_op", mdi.md_op, 3'd0);
    check("rst_stall", stall_d, 1'b0);
    check("rst_mf", ex_mf_data, 32'd0);
    check("rst_proto", proto_err, 1'b0);
`ifdef MD_HAZ_PERF_EN
    check("rst_perf", stall_cycles, 32'd0);
`endif

    // bubble carrying a divu class must not start
    set_ex(C_DIVU, 1'b0, 32'd1, 32'd1);
    id_cls = C_MFHI;
    #1;
    check("inval_start", mdi.md_start, 1'b0);
    check("inval_op", mdi.md_op, 3'd3);
    check("inval_stall", stall_d, 1'b0);
    tick();
    check("inval_proto", proto_err, 1'b0);

    // 1: mult 7 * -3, mfhi waiting in D
    set_ex(C_MULT, 1'b1, 32'd7, 32'hFFFF_FFFD);
    id_cls = C_MFHI;
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFEB);
    #1;
    check("t1_start", mdi.md_start, 1'b1);
    check("t1_op", mdi.md_op, 3'd0);
    check("t1_d1", mdi.md_d1, 32'd7);
    check("t1_d2", mdi.md_d2, 32'hFFFF_FFFD);
    check("t1_stall0", stall_d, 1'b1);
    tick();
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    #1;
    check("t1_start_once", mdi.md_start, 1'b0);
    wait_stall(n);
    check("t1_stall_len", 32'(n + 1), 32'd6);
`ifdef MD_HAZ_PERF_EN
    check("t1_perf", stall_cycles, 32'd6);
`endif
    tick();
    set_ex(C_MFHI, 1'b1, 32'd0, 32'd0);
    id_cls = C_MFLO;
    #1;
    sb_pop("t1_mfhi");
    tick();
    set_ex(C_MFLO, 1'b1, 32'd0, 32'd0);
    id_cls = C_NONE;
    #1;
    sb_pop("t1_mflo");
    check("t1_proto", proto_err, 1'b0);

    // 2: divu 100 / 7, mflo then mfhi
    tick();
    set_ex(C_DIVU, 1'b1, 32'd100, 32'd7);
    id_cls = C_MFLO;
    exp_q.push_back(32'd14);
    exp_q.push_back(32'd2);
    #1;
    check("t2_start", mdi.md_start, 1'b1);
    check("t2_op", mdi.md_op, 3'd3);
    tick();
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    #1;
    wait_stall(n);
    check("t2_stall_len", 32'(n + 1), 32'd11);
    tick();
    set_ex(C_MFLO, 1'b1, 32'd0, 32'd0);
    id_cls = C_MFHI;
    #1;
    sb_pop("t2_mflo");
    tick();
    set_ex(C_MFHI, 1'b1, 32'd0, 32'd0);
    id_cls = C_NONE;
    #1;
    sb_pop("t2_mfhi");
    tick();
    set_ex(C_MFLO, 1'b0, 32'd0, 32'd0);
    #1;
    check("t2_inval_mf", ex_mf_data, 32'd14);

    // 3: mthi then mfhi, no stall
    tick();
    set_ex(C_MTHI, 1'b1, 32'h0000_1234, 32'd0);
    id_cls = C_MFHI;
    exp_q.push_back(32'h0000_1234);
    #1;
    check("t3_start", mdi.md_start, 1'b1);
    check("t3_op", mdi.md_op, 3'd4);
    check("t3_stall", stall_d, 1'b0);
    tick();
    set_ex(C_MFHI, 1'b1, 32'd0, 32'd0);
    #1;
    sb_pop("t3_mfhi");
    check("t3_cnt_zero", stall_d, 1'b0);
    check("t3_start_mf", mdi.md_start, 1'b0);

    // 4: mult with add in D, second mult arrives at cnt=3
    tick();
    set_ex(C_MULT, 1'b1, 32'd3, 32'd5);
    id_cls = C_NONE;
    #1;
    check("t4_add_stall0", stall_d, 1'b0);
    tick();
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    #1;
    check("t4_add_stall1", stall_d, 1'b0);
    tick();
    check("t4_add_stall2", stall_d, 1'b0);
    tick();
    id_cls = C_MULT;
    #1;
    wait_stall(n);
    check("t4_mult2_wait", 32'(n), 32'd3);
    tick();
    set_ex(C_MULT, 1'b1, 32'd2, 32'd2);
    id_cls = C_MFLO;
    exp_q.push_back(32'd4);
    #1;
    check("t4_start2", mdi.md_start, 1'b1);
    tick();
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    #1;
    wait_stall(n);
    check("t4_stall_len", 32'(n + 1), 32'd6);
    tick();
    set_ex(C_MFLO, 1'b1, 32'd0, 32'd0);
    id_cls = C_NONE;
    #1;
    sb_pop("t4_mflo");
    check("t4_proto", proto_err, 1'b0);

    // 5a: div issued into E while cnt=4
    tick();
    set_ex(C_DIV, 1'b1, 32'd50, 32'd5);
    #1;
    check("t5_start", mdi.md_start, 1'b1);
    tick();
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    repeat (6) tick();
    set_ex(C_DIV, 1'b1, 32'd1, 32'd1);
    id_cls = C_MFHI;
    #1;
    check("t5_suppress", mdi.md_start, 1'b0);
    check("t5_proto_pre", proto_err, 1'b0);
    tick();
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    #1;
    check("t5_proto_issue", proto_err, 1'b1);
    wait_stall(n);
    check("t5_cnt_kept", 32'(n), 32'd3);

    // 5b: Busy dropped while counter is running
    reset = 1'b1;
    tick();
    reset = 1'b0;
    id_cls = C_NONE;
    #1;
    check("t5_proto_clr", proto_err, 1'b0);
    set_ex(C_MULT, 1'b1, 32'd1, 32'd1);
    tick();
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    busy_kill = 1'b1;
    #1;
    check("t5_kill_pre", proto_err, 1'b0);
    tick();
    check("t5_kill_err", proto_err, 1'b1);
    busy_kill = 1'b0;
    repeat (6) tick();
    check("t5_sticky", proto_err, 1'b1);

    // 6: reset at cnt=6 of a div (by zero, issued normally)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_ex(C_DIV, 1'b1, 32'd9, 32'd0);
    #1;
    check("t6_start_div0", mdi.md_start, 1'b1);
    tick();
    set_ex(C_NONE, 1'b0, 32'd0, 32'd0);
    repeat (4) tick();
    id_cls = C_MFHI;
    #1;
    check("t6_stall_pre", stall_d, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_stall", stall_d, 1'b0);
    check("t6_proto", proto_err, 1'b0);
`ifdef MD_HAZ_PERF_EN
    check("t6_perf", stall_cycles, 32'd0);
`endif
    tick();
    check("t6_proto_after", proto_err, 1'b0);
    check("t6_stall_after", stall_d, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
